// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel strobe divider, col/row scan counters, registered
// HS/VS/blank decoded from the next position, and line/frame markers.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned CLK_DIV   = 2,
  parameter bit          SYNC_POL  = 1'b0,
  parameter int unsigned CW        = 10
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  output logic          o_pix_en,
  output logic [CW-1:0] o_col,
  output logic [CW-1:0] o_row,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_blank,
  output logic          o_line_start,
  output logic          o_frame_start,
  output logic [7:0]    o_frame_cnt
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_START = CW'(H_VISIBLE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_START = CW'(V_VISIBLE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [DW-1:0] r_div;
  logic [CW-1:0] r_col;
  logic [CW-1:0] r_row;
  logic          r_hs;
  logic          r_vs;
  logic          r_blank;
  logic          r_line_start;
  logic          r_frame_start;
  logic [7:0]    r_frame_cnt;

  logic          w_pix_en;
  logic [CW-1:0] w_col_nxt;
  logic [CW-1:0] w_row_nxt;
  logic          w_line_wrap;
  logic          w_frame_wrap;
  logic          w_hs_act;
  logic          w_vs_act;
  logic          w_blank_nxt;

  assign w_pix_en = i_en && (r_div == DIV_LAST);

  always_comb begin
    w_col_nxt    = r_col;
    w_row_nxt    = r_row;
    w_line_wrap  = 1'b0;
    w_frame_wrap = 1'b0;
    if (w_pix_en) begin
      if (r_col == H_LAST) begin
        w_col_nxt   = '0;
        w_line_wrap = 1'b1;
        if (r_row == V_LAST) begin
          w_row_nxt    = '0;
          w_frame_wrap = 1'b1;
        end else begin
          w_row_nxt = r_row + 1'b1;
        end
      end else begin
        w_col_nxt = r_col + 1'b1;
      end
    end
  end

  // Decode from the next position so the registered syncs line up with col/row.
  assign w_hs_act    = (w_col_nxt >= HS_START) && (w_col_nxt <= HS_END);
  assign w_vs_act    = (w_row_nxt >= VS_START) && (w_row_nxt <= VS_END);
  assign w_blank_nxt = (w_col_nxt >= H_VIS) || (w_row_nxt >= V_VIS);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div         <= '0;
      r_col         <= '0;
      r_row         <= '0;
      r_hs          <= ~SYNC_POL;
      r_vs          <= ~SYNC_POL;
      r_blank       <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      if (i_en) begin
        r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      end
      r_col         <= w_col_nxt;
      r_row         <= w_row_nxt;
      r_hs          <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vs          <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_blank       <= w_blank_nxt;
      r_line_start  <= w_line_wrap;
      r_frame_start <= w_frame_wrap;
      if (w_frame_wrap) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  // With CLK_DIV=1 the divider is constant, so reset must gate the strobe directly.
  assign o_pix_en      = w_pix_en & ~i_rst;
  assign o_col         = r_col;
  assign o_row         = r_row;
  assign o_hs          = r_hs;
  assign o_vs          = r_vs;
  assign o_blank       = r_blank;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;
  assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three configurations driven by shared random en/rst,
// expected outputs derived from a running pixel count with plain division/modulo.
module tb_vga_timing_gen;

  localparam int N = 3;

  typedef struct packed {
    logic        pix;
    logic [15:0] col;
    logic [15:0] row;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        ls;
    logic        fs;
    logic [7:0]  fcnt;
  } exp_t;
  typedef exp_t [N-1:0] exp_vec_t;

  // Instance 0: tiny, CLK_DIV=1. Instance 1: default VGA. Instance 2: CLK_DIV=3, active-high.
  int unsigned P_HV [N] = '{8, 640, 8};
  int unsigned P_HF [N] = '{2, 16, 2};
  int unsigned P_HS [N] = '{2, 96, 3};
  int unsigned P_HB [N] = '{2, 48, 1};
  int unsigned P_VV [N] = '{4, 480, 5};
  int unsigned P_VF [N] = '{1, 10, 2};
  int unsigned P_VS [N] = '{1, 2, 1};
  int unsigned P_VB [N] = '{1, 33, 2};
  int unsigned P_DIV[N] = '{1, 2, 3};
  bit          P_POL[N] = '{1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  always #5 clk = ~clk;

  logic       pe0, hs0, vs0, bl0, ls0, fs0;
  logic [3:0] col0, row0;
  logic [7:0] fc0;
  logic       pe1, hs1, vs1, bl1, ls1, fs1;
  logic [9:0] col1, row1;
  logic [7:0] fc1;
  logic       pe2, hs2, vs2, bl2, ls2, fs2;
  logic [3:0] col2, row2;
  logic [7:0] fc2;

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .SYNC_POL(1'b0), .CW(4)
  ) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .o_pix_en(pe0), .o_col(col0), .o_row(row0),
    .o_hs(hs0), .o_vs(vs0), .o_blank(bl0), .o_line_start(ls0), .o_frame_start(fs0),
    .o_frame_cnt(fc0)
  );

  vga_timing_gen u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .o_pix_en(pe1), .o_col(col1), .o_row(row1),
    .o_hs(hs1), .o_vs(vs1), .o_blank(bl1), .o_line_start(ls1), .o_frame_start(fs1),
    .o_frame_cnt(fc1)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_VISIBLE(5), .V_FP(2), .V_SYNC(1), .V_BP(2),
    .CLK_DIV(3), .SYNC_POL(1'b1), .CW(4)
  ) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .o_pix_en(pe2), .o_col(col2), .o_row(row2),
    .o_hs(hs2), .o_vs(vs2), .o_blank(bl2), .o_line_start(ls2), .o_frame_start(fs2),
    .o_frame_cnt(fc2)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  exp_vec_t sb_q[$];

  // Reference state: pixels strobed since reset, clocks into the current pixel, last-edge markers.
  int unsigned m_p  [N];
  int unsigned m_div[N];
  bit          m_ls [N];
  bit          m_fs [N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_p[i] = 0; m_div[i] = 0; m_ls[i] = 1'b0; m_fs[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int unsigned ht, vt;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      ht = P_HV[i] + P_HF[i] + P_HS[i] + P_HB[i];
      vt = P_VV[i] + P_VF[i] + P_VS[i] + P_VB[i];
      m_ls[i] = 1'b0;
      m_fs[i] = 1'b0;
      if (en) begin
        if (m_div[i] == P_DIV[i] - 1) begin
          m_div[i] = 0;
          m_p[i]++;
          m_ls[i] = (m_p[i] % ht) == 0;
          m_fs[i] = (m_p[i] % (ht * vt)) == 0;
        end else begin
          m_div[i]++;
        end
      end
    end
  endtask

  function automatic exp_t predict(int i);
    exp_t e;
    int unsigned ht, vt, c, line, r, hs0_c, vs0_r;
    ht    = P_HV[i] + P_HF[i] + P_HS[i] + P_HB[i];
    vt    = P_VV[i] + P_VF[i] + P_VS[i] + P_VB[i];
    c     = m_p[i] % ht;
    line  = m_p[i] / ht;
    r     = line % vt;
    hs0_c = P_HV[i] + P_HF[i];
    vs0_r = P_VV[i] + P_VF[i];
    e.pix   = en && !rst && (m_div[i] == P_DIV[i] - 1);
    e.col   = 16'(c);
    e.row   = 16'(r);
    e.hs    = (c >= hs0_c && c < hs0_c + P_HS[i]) ? P_POL[i] : !P_POL[i];
    e.vs    = (r >= vs0_r && r < vs0_r + P_VS[i]) ? P_POL[i] : !P_POL[i];
    e.blank = (c >= P_HV[i]) || (r >= P_VV[i]);
    e.ls    = m_ls[i];
    e.fs    = m_fs[i];
    e.fcnt  = 8'((line / vt) % 256);
    return e;
  endfunction

  function automatic exp_t pack_act(logic pe, logic [15:0] c, logic [15:0] r, logic hs, logic vs,
                                    logic bl, logic ls, logic fs, logic [7:0] fc);
    exp_t a;
    a.pix = pe; a.col = c; a.row = r; a.hs = hs; a.vs = vs;
    a.blank = bl; a.ls = ls; a.fs = fs; a.fcnt = fc;
    return a;
  endfunction

  // Monitor: every negedge the DUTs present a full output set; pop and compare.
  initial begin
    exp_vec_t want;
    exp_vec_t got;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        want = sb_q.pop_front();
        got[0] = pack_act(pe0, 16'(col0), 16'(row0), hs0, vs0, bl0, ls0, fs0, fc0);
        got[1] = pack_act(pe1, 16'(col1), 16'(row1), hs1, vs1, bl1, ls1, fs1, fc1);
        got[2] = pack_act(pe2, 16'(col2), 16'(row2), hs2, vs2, bl2, ls2, fs2, fc2);
        for (int i = 0; i < N; i++) begin
          total++;
          if (got[i] !== want[i]) begin
            bad++;
            $display("FAIL inst%0d cyc%0d got pix=%0b col=%0d row=%0d hs=%0b vs=%0b blank=%0b ls=%0b fs=%0b fcnt=%0d required pix=%0b col=%0d row=%0d hs=%0b vs=%0b blank=%0b ls=%0b fs=%0b fcnt=%0d",
                     i, cyc, got[i].pix, got[i].col, got[i].row, got[i].hs, got[i].vs,
                     got[i].blank, got[i].ls, got[i].fs, got[i].fcnt, want[i].pix,
                     want[i].col, want[i].row, want[i].hs, want[i].vs, want[i].blank,
                     want[i].ls, want[i].fs, want[i].fcnt);
          end
        end
      end
    end
  end

  // Driver: apply the edge to the model, change inputs #1 later, push what the negedge must show.
  initial begin
    exp_vec_t e;
    model_reset();
    for (cyc = 0; cyc < 33000; cyc++) begin
      @(posedge clk);
      model_edge();
      #1;
      if (cyc < 3) begin
        rst = 1'b1; en = 1'b1;
      end else if (cyc < 2000) begin
        rst = ($urandom_range(0, 499) == 0);
        en  = ($urandom_range(0, 3) != 0);
      end else if (cyc < 31000) begin
        rst = 1'b0;
        en  = ($urandom_range(0, 15) != 0);
      end else begin
        rst = ((cyc % 1000) == 500);
        en  = !((cyc % 150) < 37);
      end
      if (rst) model_reset();
      for (int i = 0; i < N; i++) e[i] = predict(i);
      sb_q.push_back(e);
    end
    @(negedge clk);
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
